// File: rtl/sll_iter.sv
// ---------------------------------------------------------------------------
// sll_iter -- iterative logical left shifter with overflow detection.
//
// One barrel-shifter stage is applied per clock, MSB stage first, so an
// operation always takes SHW SHIFT cycles followed by one DONE cycle,
// independent of the shift amount.
//
// Ports
//   clock      sole clock, rising edge
//   reset      asynchronous, active-low reset
//   start      operation request (accepted in IDLE, and on DONE's exit edge)
//   A          operand, latched on an accepted start
//   shamt      shift amount 0..WIDTH-1, latched on an accepted start
//   busy       high while in SHIFT or DONE
//   result     A << shamt, zero-filled; valid while resultRDY is high
//   ovf        high if any 1 bit was shifted out past bit WIDTH-1
//   resultRDY  one-cycle pulse marking result/ovf valid
// ---------------------------------------------------------------------------
module sll_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             resultRDY
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [SHW-1:0]   amt;
    logic [SHW-1:0]   idx;
    logic [SHW:0]     step;
    logic [2*WIDTH-1:0] wide;
    logic             accept;

    // The edge that leaves DONE is also the first edge on which a new
    // request may be sampled, so a held start restarts every SHW+1 edges.
    assign accept = start && (state == IDLE || state == DONE);

    // Current stage: shift by 2**idx into a double-width word; the upper
    // half holds exactly the bits discarded from the top.
    always_comb begin
        step = (SHW+1)'(1) << idx;
        wide = {{WIDTH{1'b0}}, result} << step;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            resultRDY <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            amt       <= '0;
            idx       <= SHW'(SHW-1);
        end else if (accept) begin
            state     <= SHIFT;
            busy      <= 1'b1;
            resultRDY <= 1'b0;
            result    <= A;
            amt       <= shamt;
            ovf       <= 1'b0;
            idx       <= SHW'(SHW-1);
        end else begin
            case (state)
                IDLE: begin
                    busy      <= 1'b0;
                    resultRDY <= 1'b0;
                end
                SHIFT: begin
                    if (amt[idx]) begin
                        result <= wide[WIDTH-1:0];
                        ovf    <= ovf | (|wide[2*WIDTH-1:WIDTH]);
                    end
                    if (idx == '0) begin
                        state     <= DONE;
                        resultRDY <= 1'b1;
                    end else begin
                        idx <= idx - SHW'(1);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    resultRDY <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    resultRDY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sll_iter.sv
// ---------------------------------------------------------------------------
// tb_sll_iter -- self-checking bench for sll_iter (WIDTH=32, SHW=5).
// Reference: plain 64-bit arithmetic shift of the operand.
// ---------------------------------------------------------------------------
module tb_sll_iter;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clock;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             resultRDY;

    int checks = 0;
    int errors = 0;

    sll_iter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .A         (A),
        .shamt     (shamt),
        .busy      (busy),
        .result    (result),
        .ovf       (ovf),
        .resultRDY (resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  s;
        logic [31:0] exp_res;
        logic        exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void ref_sll(input logic [31:0] a, input logic [4:0] s,
                                    output logic [31:0] r, output logic o);
        logic [63:0] w;
        w = {32'b0, a} << s;
        r = w[31:0];
        o = |w[63:32];
    endfunction

    // Runs one isolated operation; returns result, ovf and latency in edges.
    task automatic do_op(input logic [31:0] a, input logic [4:0] s,
                         output logic [31:0] r, output logic o, output int lat);
        logic [31:0] held;
        @(negedge clock);
        start = 1'b1; A = a; shamt = s;
        @(posedge clock); #1;
        start = 1'b0; A = $urandom; shamt = 5'($urandom);
        chk("busy_after_start", {63'b0, busy}, 64'd1);
        lat = 0;
        while (!resultRDY && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        r = result;
        o = ovf;
        held = result;
        @(posedge clock); #1;
        chk("rdy_one_cycle", {63'b0, resultRDY}, 64'd0);
        chk("busy_idle", {63'b0, busy}, 64'd0);
        chk("result_held", {32'b0, result}, {32'b0, held});
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] r, er;
        logic        o, eo;
        int          lat, pulses, first_k, busy_ok;
        int          pk[$];

        vecs.push_back('{32'h00000001, 5'd31, 32'h80000000, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 5'd4,  32'hFFFFFFF0, 1'b1});
        vecs.push_back('{32'h0FFFFFFF, 5'd4,  32'hFFFFFFF0, 1'b0});
        vecs.push_back('{32'h12345678, 5'd0,  32'h12345678, 1'b0});
        vecs.push_back('{32'h80000000, 5'd1,  32'h00000000, 1'b1});
        vecs.push_back('{32'h80000001, 5'd16, 32'h00010000, 1'b1});
        vecs.push_back('{32'h0000FFFF, 5'd16, 32'hFFFF0000, 1'b0});
        vecs.push_back('{32'h00000000, 5'd31, 32'h00000000, 1'b0});

        start = 1'b0; A = '0; shamt = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_rdy", {63'b0, resultRDY}, 64'd0);
        chk("rst_result", {32'b0, result}, 64'd0);
        chk("rst_ovf", {63'b0, ovf}, 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].s, r, o, lat);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(SHW));
            chk($sformatf("vec%0d_res", i), {32'b0, r}, {32'b0, vecs[i].exp_res});
            chk($sformatf("vec%0d_ovf", i), {63'b0, o}, {63'b0, vecs[i].exp_ovf});
        end

        // Randomized against the reference
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [4:0]  s;
            a = $urandom;
            if (i % 3 == 0) a = a >> $urandom_range(0, 31);
            s = 5'($urandom_range(0, 31));
            ref_sll(a, s, er, eo);
            do_op(a, s, r, o, lat);
            chk("rnd_lat", 64'(lat), 64'(SHW));
            chk("rnd_res", {32'b0, r}, {32'b0, er});
            chk("rnd_ovf", {63'b0, o}, {63'b0, eo});
        end

        // start during SHIFT is ignored
        @(negedge clock);
        start = 1'b1; A = 32'h3; shamt = 5'd1;
        @(posedge clock); #1;                   // edge N
        start = 1'b0;
        busy_ok = busy ? 1 : 0;
        pulses = 0; first_k = -1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) begin start = 1'b1; A = 32'hFFFFFFFF; shamt = 5'd8; end
            @(posedge clock); #1;
            if (k == 2) start = 1'b0;
            if (k <= 5 && busy) busy_ok++;
            if (resultRDY) begin
                pulses++;
                if (first_k < 0) begin first_k = k; r = result; o = ovf; end
            end
        end
        chk("ign_busy_cont", 64'(busy_ok), 64'd6);
        chk("ign_pulses", 64'(pulses), 64'd1);
        chk("ign_pulse_at", 64'(first_k), 64'd5);
        chk("ign_res", {32'b0, r}, 64'h6);
        chk("ign_ovf", {63'b0, o}, 64'd0);

        // Reset mid-SHIFT aborts
        @(negedge clock);
        start = 1'b1; A = 32'hFFFF0000; shamt = 5'd16;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_rdy", {63'b0, resultRDY}, 64'd0);
        chk("abort_result", {32'b0, result}, 64'd0);
        chk("abort_ovf", {63'b0, ovf}, 64'd0);
        @(negedge clock) reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock); #1;
            if (resultRDY || busy) pulses++;
        end
        chk("abort_no_pulse", 64'(pulses), 64'd0);
        do_op(32'h5, 5'd2, r, o, lat);
        chk("post_abort_res", {32'b0, r}, 64'h14);
        chk("post_abort_lat", 64'(lat), 64'(SHW));

        // Back-to-back with start held high
        @(negedge clock);
        start = 1'b1; A = 32'h40000001; shamt = 5'd2;
        ref_sll(32'h40000001, 5'd2, er, eo);
        @(posedge clock); #1;                   // edge N
        busy_ok = 0;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clock); #1;
            if (busy) busy_ok++;
            if (resultRDY) begin
                pk.push_back(k);
                chk("b2b_res", {32'b0, result}, {32'b0, er});
                chk("b2b_ovf", {63'b0, ovf}, {63'b0, eo});
            end
        end
        start = 1'b0;
        chk("b2b_busy", 64'(busy_ok), 64'd17);
        chk("b2b_pulses", 64'(pk.size()), 64'd3);
        if (pk.size() == 3) begin
            chk("b2b_p0", 64'(pk[0]), 64'd5);
            chk("b2b_p1", 64'(pk[1]), 64'd11);
            chk("b2b_p2", 64'(pk[2]), 64'd17);
        end
        @(posedge clock); #1;
        chk("b2b_idle", {63'b0, busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sll_iter.md
SLL_ITER -- requirements
Module: sll_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits.
REQ-002 SHALL have parameter SHW, default 5, shift-amount width; WIDTH SHALL equal 2**SHW.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port A  input  WIDTH  operand to shift left, latched on accepted start.
REQ-007 SHALL have port shamt  input  SHW  shift amount 0..WIDTH-1, latched on accepted start.
REQ-008 SHALL have port busy  output  1  high while in SHIFT or DONE.
REQ-009 SHALL have port result  output  WIDTH  A << shamt, zero-filled; valid when resultRDY high.
REQ-010 SHALL have port ovf  output  1  high if any 1 bit was shifted out past bit WIDTH-1.
REQ-011 SHALL have port resultRDY  output  1  one-cycle pulse marking result/ovf valid.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1 at edge N: SHALL latch A into working register, latch shamt, clear ovf, set stage index to SHW-1, enter SHIFT.
REQ-014 In IDLE with start=0: SHALL hold state; result and ovf SHALL hold previous values.
REQ-015 In SHIFT, each edge SHALL process one stage, MSB first: if latched shamt[idx]=1, working register shifted left by 2**idx with zero fill, else unchanged.
REQ-016 Each SHIFT stage SHALL OR into ovf the OR of the 2**idx bits discarded from the top of the register when shamt[idx]=1.
REQ-017 SHIFT SHALL last exactly SHW edges (N+1..N+SHW) regardless of shamt value, including shamt=0.
REQ-018 After edge N+SHW, SHALL be in DONE with resultRDY=1, result and ovf final, for exactly one cycle.
REQ-019 At edge N+SHW+1, SHALL return to IDLE, resultRDY=0; result and ovf SHALL hold until next accepted start.
REQ-020 Total latency: start sampled at edge N -> resultRDY high in the cycle following edge N+SHW (N+5 for default).
REQ-021 start SHALL be ignored in SHIFT and DONE; latched A/shamt SHALL NOT change mid-operation.
REQ-022 Changes on A/shamt after edge N SHALL NOT affect the in-flight result.
REQ-023 busy SHALL be 0 in IDLE and 1 in SHIFT and DONE; a new start is accepted at the earliest at edge N+SHW+1.
REQ-024 No arithmetic fill: vacated low bits SHALL always be 0; sign bit of A SHALL NOT be preserved.

Reset
REQ-025 reset=0 SHALL immediately, independent of clock, force state IDLE, busy=0, resultRDY=0, result=0, ovf=0, stage index=SHW-1.
REQ-026 reset asserted mid-SHIFT or in DONE SHALL abort the operation; no resultRDY pulse SHALL follow.
REQ-027 First start accepted SHALL be at the first rising edge with reset=1 and start=1.

Verification
REQ-028 A=0x00000001, shamt=31, start at N -> resultRDY at N+5, result=0x80000000, ovf=0.
REQ-029 A=0xFFFFFFFF, shamt=4 -> result=0xFFFFFFF0, ovf=1; A=0x0FFFFFFF, shamt=4 -> result=0xFFFFFFF0, ovf=0.
REQ-030 A=0x12345678, shamt=0 -> resultRDY still at N+5, result=0x12345678, ovf=0.
REQ-031 Start A=0x3, shamt=1; at N+2 drive start=1, A=0xFFFFFFFF, shamt=8 -> result=0x00000006, single resultRDY pulse, busy continuous N+1..N+5.
REQ-032 Start A=0xFFFF0000, shamt=16; assert reset at N+3 -> busy, resultRDY, result, ovf 0 immediately; no pulse afterward.
REQ-033 Back-to-back: start held high continuously -> operations accepted at N, N+6, N+12; exactly one resultRDY pulse per operation.
